// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master arbiter/sequencer for main memory and video memory.
// Define ARB_RR_EN for round-robin arbitration; default is master-0 priority with a HOLD_MAX starvation guard.
module bus_arbiter #(
    parameter int MEM_LAT  = 2,
    parameter int HOLD_MAX = 8
) (
    input  logic        clk_50mhz,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic        mem_rd,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        vm_we,
    output logic [27:0] vm_addr,
    output logic [31:0] vm_wdata,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    localparam logic [2:0] LAST = 3'(MEM_LAT);
    state_t      state, state_n;
    logic [2:0]  cnt, cnt_n;
    logic        gnt, gnt_n, we_q, we_n;
    logic [31:0] addr_q, addr_n, wdata_q, wdata_n, rd_val;
    logic        mem_rd_n, mem_we_n, vm_we_n, m0_ack_n, m1_ack_n;
    logic [31:0] m0_rdata_n, m1_rdata_n;
    logic        pick1, vid_n;
    assign busy      = state != IDLE;
    assign mem_addr  = addr_q[11:0];
    assign vm_addr   = addr_q[27:0];
    assign mem_wdata = wdata_q;
    assign vm_wdata  = wdata_q;
    assign rd_val    = (addr_q[31:28] == 4'hA) ? 32'd0 : mem_rdata;
`ifdef ARB_RR_EN
    assign pick1 = m1_req && (!m0_req || !gnt);
`else
    logic [3:0] starve, starve_n;
    // master 1 is forced through once master 0 has won HOLD_MAX times in a row against it
    assign pick1 = m1_req && (!m0_req || starve >= 4'(HOLD_MAX));
    always_comb begin
        starve_n = starve;
        if (state == IDLE && (m0_req || m1_req))
            starve_n = (pick1 || !m1_req) ? 4'd0 : starve + 4'd1;
    end
    always_ff @(posedge clk_50mhz or posedge rst)
        if (rst) starve <= 4'd0;
        else     starve <= starve_n;
`endif
    assign addr_n  = (state == IDLE && (m0_req || m1_req)) ? (pick1 ? m1_addr : m0_addr) : addr_q;
    assign vid_n   = addr_n[31:28] == 4'hA;
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        gnt_n      = gnt;
        we_n       = we_q;
        wdata_n    = wdata_q;
        mem_rd_n   = mem_rd;
        mem_we_n   = mem_we;
        vm_we_n    = vm_we;
        m0_ack_n   = 1'b0;
        m1_ack_n   = 1'b0;
        m0_rdata_n = m0_rdata;
        m1_rdata_n = m1_rdata;
        case (state)
            IDLE: if (m0_req || m1_req) begin
                state_n  = ACCESS;
                cnt_n    = 3'd1;
                gnt_n    = pick1;
                we_n     = pick1 ? m1_we : m0_we;
                wdata_n  = pick1 ? m1_wdata : m0_wdata;
                mem_rd_n = !vid_n && !we_n;
                mem_we_n = !vid_n && we_n;
                vm_we_n  = vid_n && we_n;
            end
            ACCESS: if (cnt == LAST) begin
                state_n    = DONE;
                mem_rd_n   = 1'b0;
                mem_we_n   = 1'b0;
                vm_we_n    = 1'b0;
                m0_ack_n   = !gnt;
                m1_ack_n   = gnt;
                m0_rdata_n = (!gnt && !we_q) ? rd_val : m0_rdata;
                m1_rdata_n = (gnt && !we_q) ? rd_val : m1_rdata;
            end else begin
                cnt_n = cnt + 3'd1;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk_50mhz or posedge rst)
        if (rst) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            gnt      <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            mem_rd   <= 1'b0;
            mem_we   <= 1'b0;
            vm_we    <= 1'b0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rdata <= 32'd0;
            m1_rdata <= 32'd0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            gnt      <= gnt_n;
            we_q     <= we_n;
            addr_q   <= addr_n;
            wdata_q  <= wdata_n;
            mem_rd   <= mem_rd_n;
            mem_we   <= mem_we_n;
            vm_we    <= vm_we_n;
            m0_ack   <= m0_ack_n;
            m1_ack   <= m1_ack_n;
            m0_rdata <= m0_rdata_n;
            m1_rdata <= m1_rdata_n;
        end
endmodule
